// File: rtl/prbs_pkg.sv
// prbs_pkg: PRBS-15 constants, checker FSM states and seed sizing helper
package prbs_pkg;

    localparam int PRBS15_TAP_A = 14;
    localparam int PRBS15_TAP_B = 13;
    localparam int PRBS15_LEN   = 15;

    typedef enum logic [2:0] {IDLE, HUNT, SEED, CHECK, DONE} state_t;

    function automatic int seed_beats(input int dw);
        return (PRBS15_LEN + dw - 1) / dw;
    endfunction

endpackage

// File: rtl/prbs15_step.sv
// prbs15_step: unrolled PRBS-15 predictor, DATA_W bits per step, earliest bit in the MSB
module prbs15_step
    import prbs_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [PRBS15_LEN-1:0] state,
    output logic [DATA_W-1:0]     pred,
    output logic [PRBS15_LEN-1:0] next_state
);

    always_comb begin
        logic [PRBS15_LEN-1:0] s;
        logic                  b;
        s    = state;
        pred = '0;
        for (int i = 0; i < DATA_W; i++) begin
            b                 = s[PRBS15_TAP_A] ^ s[PRBS15_TAP_B];
            pred[DATA_W-1-i]  = b;
            s                 = {s[PRBS15_LEN-2:0], b};
        end
        next_state = s;
    end

endmodule

// File: rtl/prbs_link_checker.sv
// prbs_link_checker: preamble hunt, PRBS-15 self-seed and bit-error count over a check window
module prbs_link_checker
    import prbs_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int PATTERN_W = 32,
    parameter int CNT_W     = 8,
    parameter int ERR_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [PATTERN_W-1:0] pattern_in,
    input  logic [CNT_W-1:0]     n_repeats,
    input  logic [ERR_W-1:0]     check_len,
    input  logic [DATA_W-1:0]    data_in,
    input  logic                 data_valid,
    output logic                 busy,
    output logic                 pattern_found,
    output logic                 seed_err,
    output logic [ERR_W-1:0]     err_count,
    output logic                 done
);

    localparam int SEGS   = PATTERN_W / DATA_W;
    localparam int SEG_W  = SEGS > 1 ? $clog2(SEGS) : 1;
    localparam int SEED_N = seed_beats(DATA_W);
    localparam int POP_W  = $clog2(DATA_W + 1);
    localparam int SUM_W  = (ERR_W > POP_W ? ERR_W : POP_W) + 1;

    state_t                 state;
    logic [PATTERN_W-1:0]   pat_q;
    logic [CNT_W-1:0]       nrep_q;
    logic [CNT_W-1:0]       rep_cnt;
    logic [ERR_W-1:0]       clen_q;
    logic [ERR_W-1:0]       beat_cnt;
    logic [SEG_W-1:0]       seg_idx;
    logic [PRBS15_LEN-1:0]  lfsr;

    logic [DATA_W-1:0]      seg_cur;
    logic [DATA_W-1:0]      seg_first;
    logic [DATA_W-1:0]      pred;
    logic [DATA_W-1:0]      diff;
    logic [PRBS15_LEN-1:0]  lfsr_nxt;
    logic [PRBS15_LEN-1:0]  seed_nxt;
    logic [CNT_W-1:0]       rep_nxt;
    logic [CNT_W-1:0]       need;
    logic [POP_W-1:0]       pop;
    logic [SUM_W-1:0]       sum;
    logic                   seg_last;
    logic                   rep_done;
    logic                   seed_last;
    logic                   check_last;
    logic                   sat;

    prbs15_step #(.DATA_W(DATA_W)) u_step (
        .state      (lfsr),
        .pred       (pred),
        .next_state (lfsr_nxt)
    );

    // Seeding keeps only the most recent 15 received bits, newest in bit 0
    if (DATA_W >= PRBS15_LEN) begin : g_wide
        assign seed_nxt = data_in[PRBS15_LEN-1:0];
    end else begin : g_narrow
        assign seed_nxt = {lfsr[PRBS15_LEN-1-DATA_W:0], data_in};
    end

    always_comb begin
        seg_cur    = pat_q[PATTERN_W-1-int'(seg_idx)*DATA_W -: DATA_W];
        seg_first  = pat_q[PATTERN_W-1 -: DATA_W];
        seg_last   = seg_idx == SEG_W'(SEGS - 1);
        rep_nxt    = rep_cnt + CNT_W'(1);
        need       = nrep_q == '0 ? CNT_W'(1) : nrep_q;
        rep_done   = seg_last && rep_nxt == need;
        seed_last  = beat_cnt == ERR_W'(SEED_N - 1);
        check_last = beat_cnt == clen_q - ERR_W'(1);
        diff       = pred ^ data_in;
        pop        = '0;
        for (int i = 0; i < DATA_W; i++)
            pop = pop + POP_W'(diff[i]);
        sum = SUM_W'(err_count) + SUM_W'(pop);
        sat = sum > SUM_W'({ERR_W{1'b1}});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            pat_q         <= '0;
            nrep_q        <= '0;
            clen_q        <= '0;
            rep_cnt       <= '0;
            beat_cnt      <= '0;
            seg_idx       <= '0;
            lfsr          <= '0;
            busy          <= 1'b0;
            pattern_found <= 1'b0;
            seed_err      <= 1'b0;
            err_count     <= '0;
            done          <= 1'b0;
        end else if (start) begin
            state         <= HUNT;
            pat_q         <= pattern_in;
            nrep_q        <= n_repeats;
            clen_q        <= check_len;
            rep_cnt       <= '0;
            beat_cnt      <= '0;
            seg_idx       <= '0;
            lfsr          <= '0;
            busy          <= 1'b1;
            pattern_found <= 1'b0;
            seed_err      <= 1'b0;
            err_count     <= '0;
            done          <= 1'b0;
        end else begin
            case (state)
                HUNT: if (data_valid) begin
                    if (data_in == seg_cur) begin
                        seg_idx <= seg_last ? '0 : seg_idx + SEG_W'(1);
                        if (seg_last) rep_cnt <= rep_nxt;
                        if (rep_done) begin
                            pattern_found <= 1'b1;
                            state         <= SEED;
                            beat_cnt      <= '0;
                        end
                    end else begin
                        // A failed beat may itself open a new preamble
                        rep_cnt <= '0;
                        seg_idx <= (SEGS > 1 && data_in == seg_first) ? SEG_W'(1) : '0;
                    end
                end
                SEED: if (data_valid) begin
                    lfsr     <= seed_nxt;
                    beat_cnt <= seed_last ? '0 : beat_cnt + ERR_W'(1);
                    if (seed_last) begin
                        if (seed_nxt == '0) begin
                            seed_err <= 1'b1;
                            state    <= HUNT;
                            seg_idx  <= '0;
                            rep_cnt  <= '0;
                        end else if (clen_q == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            state <= CHECK;
                        end
                    end
                end
                CHECK: if (data_valid) begin
                    err_count <= sat ? '1 : sum[ERR_W-1:0];
                    lfsr      <= lfsr_nxt;
                    beat_cnt  <= beat_cnt + ERR_W'(1);
                    if (check_last) begin
                        state <= DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_prbs_link_checker.sv
// tb_prbs_link_checker: directed vectors for preamble hunt, seeding, error counting and handshake
`timescale 1ns/1ps
module tb_prbs_link_checker;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        data_valid = 1'b0;
    logic [31:0] pattern_in = 32'hDEADBEEF;
    logic [7:0]  n_repeats = 8'd3;
    logic [15:0] check_len = 16'd100;
    logic [7:0]  data_in = 8'h00;
    logic        busy, pattern_found, seed_err, done;
    logic [15:0] err_count;
    logic        busy4, found4, seed_err4, done4;
    logic [3:0]  err4;

    int          vectors = 0;
    int          miscompares = 0;
    logic [7:0]  prbs [0:127];
    logic [7:0]  mask [0:127];
    bit          gap = 1'b0;
    longint      t0;

    always #5 clk = ~clk;

    prbs_link_checker dut (
        .clk(clk), .rst_n(rst_n), .start(start), .pattern_in(pattern_in),
        .n_repeats(n_repeats), .check_len(check_len), .data_in(data_in),
        .data_valid(data_valid), .busy(busy), .pattern_found(pattern_found),
        .seed_err(seed_err), .err_count(err_count), .done(done)
    );

    prbs_link_checker #(.ERR_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start), .pattern_in(pattern_in),
        .n_repeats(n_repeats), .check_len(check_len[3:0]), .data_in(data_in),
        .data_valid(data_valid), .busy(busy4), .pattern_found(found4),
        .seed_err(seed_err4), .err_count(err4), .done(done4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] pb(input int i);
        logic [31:0] p;
        p = 32'hDEADBEEF;
        return p[31-8*(i%4) -: 8];
    endfunction

    task automatic beat(input logic [7:0] d);
        if (gap) begin
            data_valid = 1'b0;
            data_in    = 8'h5A;
            @(posedge clk); #1;
        end
        data_in    = d;
        data_valid = 1'b1;
        @(posedge clk); #1;
        data_valid = 1'b0;
    endtask

    task automatic go(input logic [7:0] n, input logic [15:0] len, input logic [7:0] d, input bit v);
        pattern_in = 32'hDEADBEEF;
        n_repeats  = n;
        check_len  = len;
        data_in    = d;
        data_valid = v;
        start      = 1'b1;
        @(posedge clk); #1;
        start      = 1'b0;
        data_valid = 1'b0;
        pattern_in = 32'h0;
        n_repeats  = 8'hFF;
        check_len  = 16'hFFFF;
    endtask

    task automatic pre(input int n);
        for (int i = 0; i < n; i++) beat(pb(i));
    endtask

    task automatic stream(input int first, input int n);
        for (int j = first; j < first + n; j++) beat(prbs[j] ^ mask[j]);
    endtask

    task automatic clear_mask();
        for (int j = 0; j < 128; j++) mask[j] = 8'h00;
    endtask

    initial begin
        bit b [0:1023];
        for (int i = 0; i < 1024; i++) b[i] = (i < 15) ? 1'b1 : (b[i-15] ^ b[i-14]);
        for (int j = 0; j < 128; j++)
            for (int k = 0; k < 8; k++) prbs[j][7-k] = b[8*j+k];
        clear_mask();

        #1;
        check("rst_busy", 32'(busy), 0);
        check("rst_flags", {pattern_found, seed_err, done}, 0);
        check("rst_err", 32'(err_count), 0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("idle_busy", 32'(busy), 0);

        // 1: clean run
        go(8'd3, 16'd100, 8'h00, 1'b0);
        check("t1_busy", 32'(busy), 1);
        pre(11);
        check("t1_found_early", 32'(pattern_found), 0);
        beat(pb(11));
        check("t1_found", 32'(pattern_found), 1);
        stream(0, 101);
        check("t1_done_early", 32'(done), 0);
        stream(101, 1);
        check("t1_done", 32'(done), 1);
        check("t1_err", 32'(err_count), 0);
        check("t1_busy_drop", 32'(busy), 0);
        @(posedge clk); #1;
        check("t1_done_pulse", 32'(done), 0);
        check("t1_found_hold", 32'(pattern_found), 1);

        // 2: injected bit errors
        for (int j = 2; j < 7; j++) mask[j] = 8'h01;
        mask[10] = 8'hF0;
        go(8'd3, 16'd100, 8'h00, 1'b0);
        pre(12);
        stream(0, 102);
        check("t2_done", 32'(done), 1);
        check("t2_err", 32'(err_count), 9);
        clear_mask();

        // 3: broken preamble, restart on the false-start byte
        go(8'd3, 16'd20, 8'h00, 1'b0);
        pre(4);
        beat(8'hDE); beat(8'hAD); beat(8'hDE);
        beat(8'hAD); beat(8'hBE); beat(8'hEF);
        pre(7);
        check("t3_found_early", 32'(pattern_found), 0);
        beat(8'hEF);
        check("t3_found", 32'(pattern_found), 1);
        stream(0, 22);
        check("t3_done", 32'(done), 1);
        check("t3_err", 32'(err_count), 0);

        // 4: all-zero seed then recovery
        go(8'd3, 16'd20, 8'h00, 1'b0);
        pre(12);
        beat(8'h00); beat(8'h00);
        check("t4_seed_err", 32'(seed_err), 1);
        check("t4_found_hold", 32'(pattern_found), 1);
        check("t4_busy", 32'(busy), 1);
        pre(12);
        stream(0, 22);
        check("t4_done", 32'(done), 1);
        check("t4_err", 32'(err_count), 0);
        check("t4_seed_err_hold", 32'(seed_err), 1);

        // 5a: valid toggling every other cycle
        gap = 1'b1;
        go(8'd3, 16'd100, 8'h00, 1'b0);
        t0 = $time;
        pre(12);
        stream(0, 101);
        check("t5_done_early", 32'(done), 0);
        stream(101, 1);
        check("t5_done", 32'(done), 1);
        check("t5_err", 32'(err_count), 0);
        check("t5_cycles", 32'(($time - t0) / 10), 228);
        gap = 1'b0;

        // 5b: restart mid-check; beat on the start cycle is dropped
        mask[2] = 8'h03;
        go(8'd3, 16'd100, 8'h00, 1'b0);
        pre(12);
        stream(0, 5);
        check("t5b_err_mid", 32'(err_count), 2);
        clear_mask();
        go(8'd3, 16'd20, 8'hDE, 1'b1);
        check("t5b_err_clr", 32'(err_count), 0);
        check("t5b_found_clr", 32'(pattern_found), 0);
        check("t5b_busy", 32'(busy), 1);
        beat(8'hAD); beat(8'hBE); beat(8'hEF);
        pre(8);
        check("t5b_start_beat_dropped", 32'(pattern_found), 0);
        pre(4);
        check("t5b_found", 32'(pattern_found), 1);
        stream(0, 22);
        check("t5b_done", 32'(done), 1);
        check("t5b_err", 32'(err_count), 0);

        // 6a: inverted stream saturates a narrow counter
        for (int j = 2; j < 12; j++) mask[j] = 8'hFF;
        go(8'd3, 16'd10, 8'h00, 1'b0);
        pre(12);
        stream(0, 12);
        check("t6_done4", 32'(done4), 1);
        check("t6_err_sat", 32'(err4), 15);
        check("t6_err_wide", 32'(err_count), 80);
        clear_mask();

        // 6b: n_repeats=0 and check_len=0
        go(8'd0, 16'd0, 8'h00, 1'b0);
        pre(3);
        check("t6b_found_early", 32'(pattern_found), 0);
        beat(pb(3));
        check("t6b_found", 32'(pattern_found), 1);
        stream(0, 1);
        check("t6b_done_early", 32'(done), 0);
        stream(1, 1);
        check("t6b_done", 32'(done), 1);
        check("t6b_err", 32'(err_count), 0);
        check("t6b_busy", 32'(busy), 0);

        // async reset mid-run
        go(8'd3, 16'd100, 8'h00, 1'b0);
        pre(12);
        stream(0, 10);
        rst_n = 1'b0;
        #1;
        check("rst_mid_busy", 32'(busy), 0);
        check("rst_mid_found", 32'(pattern_found), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
